alu_seq_w: RTL
==============

# alu_seq_w

Parametrised, registered successor to the 16-bit single-cycle ALU. It performs the same operation set (ADD, SUB, XOR, RED, SLL, SRA, ROR, PADDSB, AND, OR) at any lane-aligned width WIDTH. It adds a valid/ready handshake on both sides, a registered result with back-pressure, and an optional iterative signed multiply. It sits between the decode/register-read stage and writeback, and owns the N/V/Z flag register.

## Interface
- WIDTH, 16, datapath width; multiple of 8, minimum 8.
- SHW, $clog2(WIDTH), derived; shift-amount width.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  operation presented.
- in_ready  out  1  block accepts an operation this cycle.
- opcode  in  4  operation select.
- rs  in  WIDTH  operand A.
- rt  in  WIDTH  operand B.
- shamt  in  SHW  shift/rotate amount.
- out_valid  out  1  rd/flag hold a result.
- out_ready  in  1  consumer takes the result.
- rd  out  WIDTH  registered result.
- flag  out  3  {N,V,Z} = flag[2:0]; registered.
- busy  out  1  multiply in progress.

## Operation
- Accept happens when in_valid && in_ready. Result leaves when out_valid && out_ready.
- Opcodes:
  - 0 ADD: rs+rt, wrapping.
  - 1 SUB: rs-rt.
  - 2 XOR.
  - 3 RED: signed sum of all 8-bit lanes of rs and rt, sign-extended to WIDTH.
  - 4 SLL.
  - 5 SRA.
  - 6 ROR by shamt.
  - 7 PADDSB: per 4-bit lane signed saturating add.
  - 8 AND.
  - 9 OR.
  - 10 MUL: see Configuration.
  - 11–15 illegal: rd=0, no flag update, 1-cycle latency.
- Flag updates are written in the same cycle rd is loaded:
  - Z is updated by ADD, SUB, XOR, SLL, SRA, ROR, MUL; Z=(result==0).
  - V and N are updated by ADD and SUB only.
  - V is signed overflow. N is result[WIDTH-1].
  - Flags not updated hold their previous value.
- States:
  - IDLE: output register empty, or draining with out_ready.
  - MUL: iterating.
  - HOLD: out_valid=1 && out_ready=0.
- State transitions:
  - IDLE→MUL on accepting opcode 10.
  - IDLE→HOLD on accepting a 1-cycle op while out_ready=0 the next cycle.
  - MUL→IDLE/HOLD when the counter reaches WIDTH.
  - HOLD→IDLE on out_ready.
- in_ready = (state!=MUL) && (!out_valid || out_ready). This allows back-to-back single-cycle ops at full rate.
- Simultaneous drain and accept in the same cycle: the old result is consumed and the new result is loaded. No bubble.
- While out_valid=1 and out_ready=0: rd and flag are stable, and inputs are ignored.
- Reset values: out_valid=0, rd=0, flag=3'b000, busy=0, state IDLE, MUL counter 0. in_ready=1 after reset deasserts.
- Reset asserted mid-MUL aborts the operation; no result is produced.

## Timing
- Single-cycle ops: accept at edge T → rd, flag, out_valid valid after edge T+1.
- MUL: accept at edge T → busy=1 from T+1. Result and out_valid arrive after edge T+WIDTH, with busy falling in the same edge.
- in_ready is combinational from state, out_valid and out_ready. There is no combinational path from in_valid to out_valid.
- rst sampled low at edge T → all registers at reset values after T.

## Configuration
- ALU_SEQ_MUL_EN defined:
  - Opcode 10 is a radix-2 shift-add signed multiply over WIDTH cycles.
  - rd = low WIDTH bits of rs*rt.
  - Z is updated; N and V are unchanged.
  - busy is driven.
- ALU_SEQ_MUL_EN undefined:
  - No MUL state or counter is built.
  - Opcode 10 behaves as illegal (rd=0, 1-cycle latency, flags held).
  - busy is tied 0.

## Test plan
- ADD rs=0x7FFF, rt=0x0001, out_ready=1 → next cycle rd=0x8000, out_valid=1, flag={N=1,V=1,Z=0}. Then SUB 0x1234−0x1234 → rd=0x0000, flag={0,0,1}.
- Back-pressure: ADD accepted, out_ready=0 for 3 cycles, new in_valid presented → in_ready=0 and rd unchanged for 3 cycles. The next op is accepted in the cycle out_ready=1, with rd updated the following edge.
- Lane ops:
  - PADDSB rs=0x7777, rt=0x1111 → rd=0x7777, flag unchanged.
  - ROR rs=0x1234, shamt=4 → rd=0x4123, Z=0.
  - RED rs=0x00FF, rt=0x0101 → rd=0x0001.
- With ALU_SEQ_MUL_EN: MUL rs=0xFFFD, rt=0x0007 → busy=1 for 16 cycles, in_ready=0 throughout, then rd=0xFFEB, out_valid=1, Z=0. Without the macro: the same op gives rd=0x0000 after 1 cycle, flags unchanged.
- Reset mid-MUL: rst=0 at cycle 5 of MUL → after that edge out_valid=0, busy=0, flag=000, rd=0. in_ready=1 once rst=1.
- WIDTH=32 regression: ADD 0x7FFFFFFF+1 → rd=0x80000000, V=1. SRA 0x80000000 by 31 → rd=0xFFFFFFFF.

Source files
------------

// File: rtl/alu_seq_w.sv
// alu_seq_w: registered ALU with valid/ready handshakes on both sides and
// an owned N/V/Z flag register. Defining ALU_SEQ_MUL_EN adds an iterative
// radix-2 shift-add signed multiply on opcode 10. Without it, opcode 10 is illegal.
module alu_seq_w #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   input  logic [SHW-1:0]   shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] rd,
   output logic [2:0]       flag,
   output logic             busy
);

   localparam logic [3:0] OP_ADD    = 4'd0;
   localparam logic [3:0] OP_SUB    = 4'd1;
   localparam logic [3:0] OP_XOR    = 4'd2;
   localparam logic [3:0] OP_RED    = 4'd3;
   localparam logic [3:0] OP_SLL    = 4'd4;
   localparam logic [3:0] OP_SRA    = 4'd5;
   localparam logic [3:0] OP_ROR    = 4'd6;
   localparam logic [3:0] OP_PADDSB = 4'd7;
   localparam logic [3:0] OP_AND    = 4'd8;
   localparam logic [3:0] OP_OR     = 4'd9;

`ifdef ALU_SEQ_MUL_EN
   localparam logic [3:0]     OP_MUL   = 4'd10;
   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1, S_MUL = 2'd2} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1} state_t;
`endif

   // Signed sum of every 8-bit lane of both operands, wrapped to WIDTH.
   function automatic logic [WIDTH-1:0] red_sum(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      logic signed [WIDTH+7:0] acc;
      logic signed [WIDTH+7:0] la;
      logic signed [WIDTH+7:0] lb;
      acc = '0;
      for (int i = 0; i < WIDTH / 8; i++) begin
         la  = {{WIDTH{a[8*i+7]}}, a[8*i +: 8]};
         lb  = {{WIDTH{b[8*i+7]}}, b[8*i +: 8]};
         acc = acc + la + lb;
      end
      return acc[WIDTH-1:0];
   endfunction

   // Per 4-bit lane signed add, clamped to [-8, 7].
   function automatic logic [WIDTH-1:0] padd_sat4(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      logic signed [4:0] s;
      r = '0;
      for (int i = 0; i < WIDTH / 4; i++) begin
         s = $signed({a[4*i+3], a[4*i +: 4]}) + $signed({b[4*i+3], b[4*i +: 4]});
         if (s > 5'sd7)       r[4*i +: 4] = 4'h7;
         else if (s < -5'sd8) r[4*i +: 4] = 4'h8;
         else                 r[4*i +: 4] = s[3:0];
      end
      return r;
   endfunction

   // Rotate right: the low half of the doubled word shifted right.
   function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] a,
                                                  input logic [SHW-1:0]   sh);
      logic [2*WIDTH-1:0] dbl;
      dbl = {a, a} >> sh;
      return dbl[WIDTH-1:0];
   endfunction

   function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                    input logic signed [WIDTH-1:0] b,
                                    input logic signed [WIDTH-1:0] s);
      return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
   endfunction

   function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                    input logic signed [WIDTH-1:0] b,
                                    input logic signed [WIDTH-1:0] d);
      return (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
   endfunction

   state_t                   state_q;
   logic                     out_valid_q;
   logic [WIDTH-1:0]         rd_q;
   logic [2:0]               flag_q;
   logic [WIDTH-1:0]         res_d;
   logic [2:0]               flag_d;
   logic                     accept;
   logic signed [WIDTH-1:0]  a_s;
   logic signed [WIDTH-1:0]  b_s;
   logic signed [WIDTH-1:0]  sum_s;
   logic signed [WIDTH-1:0]  diff_s;
   logic [WIDTH-1:0]         ror_v;

   assign a_s    = $signed(rs);
   assign b_s    = $signed(rt);
   assign sum_s  = a_s + b_s;
   assign diff_s = a_s - b_s;
   assign ror_v  = rot_right(rs, shamt);

`ifdef ALU_SEQ_MUL_EN
   logic             busy_q;
   logic [SHW-1:0]   cnt_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic [WIDTH-1:0] acc_d;

   // Low WIDTH bits of a two's-complement product equal those of the unsigned
   // product, so plain shift-add over WIDTH steps yields the signed result.
   assign acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign in_ready = (state_q != S_MUL) && (!out_valid_q || out_ready);
   assign busy     = busy_q;
`else
   assign in_ready = !out_valid_q || out_ready;
   assign busy     = 1'b0;
`endif

   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign rd        = rd_q;
   assign flag      = flag_q;

   // Single-cycle result and next flag value; unlisted opcodes give 0 and hold flags.
   always_comb begin
      res_d  = '0;
      flag_d = flag_q;
      case (opcode)
         OP_ADD: begin
            res_d  = sum_s;
            flag_d = {sum_s[WIDTH-1], add_ovf(a_s, b_s, sum_s), sum_s == '0};
         end
         OP_SUB: begin
            res_d  = diff_s;
            flag_d = {diff_s[WIDTH-1], sub_ovf(a_s, b_s, diff_s), diff_s == '0};
         end
         OP_XOR: begin
            res_d     = rs ^ rt;
            flag_d[0] = ((rs ^ rt) == '0);
         end
         OP_RED:    res_d = red_sum(rs, rt);
         OP_SLL: begin
            res_d     = rs << shamt;
            flag_d[0] = ((rs << shamt) == '0);
         end
         OP_SRA: begin
            res_d     = a_s >>> shamt;
            flag_d[0] = ((a_s >>> shamt) == '0);
         end
         OP_ROR: begin
            res_d     = ror_v;
            flag_d[0] = (ror_v == '0);
         end
         OP_PADDSB: res_d = padd_sat4(rs, rt);
         OP_AND:    res_d = rs & rt;
         OP_OR:     res_d = rs | rt;
         default:   res_d = '0;
      endcase
   end

   // Control FSM with the result/flag registers and the multiply iteration.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
         rd_q        <= '0;
         flag_q      <= 3'b000;
`ifdef ALU_SEQ_MUL_EN
         busy_q      <= 1'b0;
         cnt_q       <= '0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
`endif
      end else begin
         case (state_q)
`ifdef ALU_SEQ_MUL_EN
            S_MUL: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  rd_q        <= acc_d;
                  flag_q[0]   <= (acc_d == '0);
                  out_valid_q <= 1'b1;
                  busy_q      <= 1'b0;
                  cnt_q       <= '0;
                  state_q     <= S_HOLD;
               end
            end
`endif
            default: begin
               if (accept) begin
`ifdef ALU_SEQ_MUL_EN
                  if (opcode == OP_MUL) begin
                     out_valid_q <= 1'b0;
                     busy_q      <= 1'b1;
                     cnt_q       <= '0;
                     acc_q       <= '0;
                     mcand_q     <= rs;
                     mplier_q    <= rt;
                     state_q     <= S_MUL;
                  end else begin
                     rd_q        <= res_d;
                     flag_q      <= flag_d;
                     out_valid_q <= 1'b1;
                     state_q     <= S_HOLD;
                  end
`else
                  rd_q        <= res_d;
                  flag_q      <= flag_d;
                  out_valid_q <= 1'b1;
                  state_q     <= S_HOLD;
`endif
               end else if (out_valid_q && out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule
